// File: rtl/cpu_clock_controller_pkg.sv
// Shared definitions for the Mini-SRC CPU clock controller: FSM state encodings
// and default divider configuration, also consumed by the LED/debug display block.
package cpu_clock_controller_pkg;

    localparam int          CLK_DIV_W       = 28;
    localparam int unsigned CLK_DEFAULT_DIV = 10000000;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_RUN    = 2'b01,
        ST_STEP   = 2'b10,
        ST_HALTED = 2'b11
    } clk_state_e;

    // True for states in which the CPU may legally receive a clock enable.
    function automatic logic state_can_tick(input clk_state_e st);
        return (st == ST_RUN) || (st == ST_STEP);
    endfunction

endpackage

// File: rtl/cpu_clock_controller_if.sv
// Request/response bundle between the board/CPU-halt side and the clock controller.
interface cpu_clock_controller_if #(
    parameter int DIV_W = 28
);
    logic             run_req;
    logic             step_req;
    logic             stop_req;
    logic             halt_req;
    logic             div_load;
    logic [DIV_W-1:0] div_in;
    logic             cpu_tick;
    logic [1:0]       state_o;
    logic [31:0]      tick_count;

    modport master (
        output run_req, step_req, stop_req, halt_req, div_load, div_in,
        input  cpu_tick, state_o, tick_count
    );

    modport slave (
        input  run_req, step_req, stop_req, halt_req, div_load, div_in,
        output cpu_tick, state_o, tick_count
    );
endinterface

// File: rtl/cpu_clock_controller_tick_gen.sv
// Runtime-loadable tick divider: holds the divisor and the free-running count,
// and flags the terminal count while enabled.
module cpu_clock_controller_tick_gen
    import cpu_clock_controller_pkg::*;
#(
    parameter int          DIV_W       = CLK_DIV_W,
    parameter int unsigned DEFAULT_DIV = CLK_DEFAULT_DIV
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic             load,
    input  logic [DIV_W-1:0] div_in,
    output logic             tc
);

    logic [DIV_W-1:0] div_reg_q, div_reg_d;
    logic [DIV_W-1:0] counter_q, counter_d;
    logic [DIV_W-1:0] div_eff;
    logic [DIV_W-1:0] term;

    // Divisors 0 and 1 both mean "every cycle", so clamp before subtracting.
    always_comb begin
        div_eff = (div_reg_q <= DIV_W'(1)) ? DIV_W'(1) : div_reg_q;
        term    = div_eff - DIV_W'(1);
    end

    // A load always restarts the count and never coincides with a terminal count.
    assign tc = enable && !load && (counter_q == term);

    always_comb begin
        div_reg_d = div_reg_q;
        counter_d = counter_q + DIV_W'(1);
        if (load) begin
            div_reg_d = div_in;
            counter_d = '0;
        end else if (!enable || tc) begin
            counter_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            div_reg_q <= DIV_W'(DEFAULT_DIV);
            counter_q <= '0;
        end else begin
            div_reg_q <= div_reg_d;
            counter_q <= counter_d;
        end
    end

endmodule

// File: rtl/cpu_clock_controller.sv
// Run/step/halt sequencer producing a one-cycle CPU clock enable on in_clock.
// Define CLOCK_CTRL_CYCLE_COUNT_EN to enable the issued-tick counter on tick_count.
module cpu_clock_controller
    import cpu_clock_controller_pkg::*;
#(
    parameter int          DIV_W       = CLK_DIV_W,
    parameter int unsigned DEFAULT_DIV = CLK_DEFAULT_DIV
) (
    input  logic                   in_clock,
    input  logic                   reset,
    cpu_clock_controller_if.slave  bus
);

    clk_state_e state_q, state_d;
    logic       cpu_tick_q, cpu_tick_d;
    logic       run_active;
    logic       tc;

    // Counting only continues while RUN will still be the state next cycle.
    assign run_active = (state_q == ST_RUN) && !bus.halt_req && !bus.stop_req;

    cpu_clock_controller_tick_gen #(
        .DIV_W       (DIV_W),
        .DEFAULT_DIV (DEFAULT_DIV)
    ) u_tick_gen (
        .clk    (in_clock),
        .rst    (reset),
        .enable (run_active),
        .load   (bus.div_load),
        .div_in (bus.div_in),
        .tc     (tc)
    );

    always_comb begin
        state_d    = state_q;
        cpu_tick_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.halt_req) begin
                    state_d = ST_HALTED;
                end else if (!bus.stop_req) begin
                    if (bus.run_req) begin
                        state_d = ST_RUN;
                    end else if (bus.step_req) begin
                        state_d    = ST_STEP;
                        cpu_tick_d = 1'b1;
                    end
                end
            end
            ST_RUN: begin
                if (bus.halt_req) begin
                    state_d = ST_HALTED;
                end else if (bus.stop_req) begin
                    state_d = ST_IDLE;
                end else begin
                    cpu_tick_d = tc;
                end
            end
            ST_STEP: begin
                state_d = bus.halt_req ? ST_HALTED : ST_IDLE;
            end
            ST_HALTED: begin
                state_d = ST_HALTED;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        // Belt and braces: the enable can only leave in a state that permits it.
        if (!state_can_tick(state_d)) begin
            cpu_tick_d = 1'b0;
        end
    end

    always_ff @(posedge in_clock) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            cpu_tick_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cpu_tick_q <= cpu_tick_d;
        end
    end

`ifdef CLOCK_CTRL_CYCLE_COUNT_EN
    logic [31:0] tick_count_q, tick_count_d;

    always_comb begin
        tick_count_d = tick_count_q + {31'd0, cpu_tick_q};
    end

    always_ff @(posedge in_clock) begin
        if (reset) begin
            tick_count_q <= 32'd0;
        end else begin
            tick_count_q <= tick_count_d;
        end
    end

    assign bus.tick_count = tick_count_q;
`else
    assign bus.tick_count = 32'd0;
`endif

    assign bus.cpu_tick = cpu_tick_q;
    assign bus.state_o  = state_q;

endmodule

// File: tb/tb_cpu_clock_controller.sv
// Self-checking bench for cpu_clock_controller: vector table, directed corner
// sequences and randomized traffic against a cycle-level behavioural model.
module tb_cpu_clock_controller;
    import cpu_clock_controller_pkg::*;

    localparam int          DIV_W   = 28;
    localparam int unsigned DEF_DIV = 6;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    cpu_clock_controller_if #(.DIV_W(DIV_W)) bus ();

    cpu_clock_controller #(
        .DIV_W       (DIV_W),
        .DEFAULT_DIV (DEF_DIV)
    ) dut (
        .in_clock (clk),
        .reset    (rst),
        .bus      (bus)
    );

    int errors = 0;
    int checks = 0;

    // Behavioural model: state, expected enable, ticks issued, divisor, cycles into period.
    int          m_state;
    bit          m_tick;
    int unsigned m_cnt;
    longint      m_div;
    longint      m_phase;

    typedef struct {
        logic       r, run, step, stop, halt, load;
        logic [7:0] d;
        logic       tick;
        logic [1:0] st;
    } vec_t;
    vec_t vecs[18];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic r, input logic run, input logic step, input logic stop,
                         input logic halt, input logic load, input logic [7:0] d);
        rst          = r;
        bus.run_req  = run;
        bus.step_req = step;
        bus.stop_req = stop;
        bus.halt_req = halt;
        bus.div_load = load;
        bus.div_in   = DIV_W'(d);
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, 0, 0, 8'd0);
    endtask

    // Apply the rules: one period is max(div,1) RUN cycles, ending in a tick.
    task automatic model_update();
        longint eff;
        bit     nt;
        eff = (m_div < 2) ? 1 : m_div;
        nt  = 0;
        if (rst) begin
            m_state = 0; m_phase = 0; m_div = DEF_DIV; m_cnt = 0;
        end else begin
`ifdef CLOCK_CTRL_CYCLE_COUNT_EN
            if (m_tick) m_cnt = m_cnt + 1;
`endif
            case (m_state)
                0: begin
                    if (bus.halt_req) m_state = 3;
                    else if (bus.stop_req) m_state = 0;
                    else if (bus.run_req) begin m_state = 1; m_phase = 0; end
                    else if (bus.step_req) begin m_state = 2; nt = 1; end
                end
                1: begin
                    if (bus.halt_req) begin m_state = 3; m_phase = 0; end
                    else if (bus.stop_req) begin m_state = 0; m_phase = 0; end
                    else if (!bus.div_load) begin
                        m_phase = m_phase + 1;
                        if (m_phase == eff) begin nt = 1; m_phase = 0; end
                    end
                end
                2: m_state = bus.halt_req ? 3 : 0;
                default: m_state = 3;
            endcase
            if (bus.div_load) begin
                m_div   = longint'(bus.div_in);
                m_phase = 0;
            end
        end
        m_tick = nt;
    endtask

    task automatic cyc();
        @(posedge clk);
        model_update();
        #1;
        check("model_tick", {31'd0, bus.cpu_tick}, {31'd0, m_tick});
        check("model_state", {30'd0, bus.state_o}, m_state);
        check("model_count", bus.tick_count, m_cnt);
    endtask

    initial begin
        int          k;
        int          first;
        logic [31:0] mask;
        logic [31:0] exp_cnt;

        m_state = 0; m_tick = 0; m_cnt = 0; m_div = DEF_DIV; m_phase = 0;
        drive(1, 0, 0, 0, 0, 0, 8'd0);
        cyc();
        check("reset_tick", {31'd0, bus.cpu_tick}, 32'd0);
        check("reset_state", {30'd0, bus.state_o}, {30'd0, ST_IDLE});
        check("reset_count", bus.tick_count, 32'd0);

        //            r run stp stop hlt load d      tick st
        vecs[0]  = '{1, 0, 0, 0, 0, 0, 8'd0, 0, 2'b00};
        vecs[1]  = '{0, 0, 0, 0, 0, 0, 8'd0, 0, 2'b00};
        vecs[2]  = '{0, 0, 1, 0, 0, 0, 8'd0, 1, 2'b10};
        vecs[3]  = '{0, 0, 0, 0, 0, 0, 8'd0, 0, 2'b00};
        vecs[4]  = '{0, 0, 0, 0, 0, 1, 8'd1, 0, 2'b00};
        vecs[5]  = '{0, 1, 0, 0, 0, 0, 8'd0, 0, 2'b01};
        vecs[6]  = '{0, 0, 0, 0, 0, 0, 8'd0, 1, 2'b01};
        vecs[7]  = '{0, 0, 0, 0, 0, 0, 8'd0, 1, 2'b01};
        vecs[8]  = '{0, 0, 1, 0, 0, 0, 8'd0, 1, 2'b01};
        vecs[9]  = '{0, 0, 0, 1, 0, 0, 8'd0, 0, 2'b00};
        vecs[10] = '{0, 1, 0, 0, 0, 0, 8'd0, 0, 2'b01};
        vecs[11] = '{0, 0, 0, 0, 0, 0, 8'd0, 1, 2'b01};
        vecs[12] = '{0, 1, 0, 0, 1, 0, 8'd0, 0, 2'b11};
        vecs[13] = '{0, 0, 1, 0, 0, 0, 8'd0, 0, 2'b11};
        vecs[14] = '{0, 1, 0, 0, 0, 0, 8'd0, 0, 2'b11};
        vecs[15] = '{1, 0, 0, 0, 0, 0, 8'd0, 0, 2'b00};
        vecs[16] = '{0, 0, 1, 0, 1, 0, 8'd0, 0, 2'b11};
        vecs[17] = '{1, 0, 0, 0, 0, 0, 8'd0, 0, 2'b00};
        for (int i = 0; i < 18; i++) begin
            drive(vecs[i].r, vecs[i].run, vecs[i].step, vecs[i].stop,
                  vecs[i].halt, vecs[i].load, vecs[i].d);
            cyc();
            check($sformatf("vec%0d_tick", i), {31'd0, bus.cpu_tick}, {31'd0, vecs[i].tick});
            check($sformatf("vec%0d_state", i), {30'd0, bus.state_o}, {30'd0, vecs[i].st});
        end

        // Default divisor after reset: first tick 6 cycles after run.
        drive(1, 0, 0, 0, 0, 0, 8'd0); cyc();
        drive(0, 1, 0, 0, 0, 0, 8'd0); cyc();
        mask = '0;
        for (int c = 1; c <= 8; c++) begin
            idle(); cyc();
            if (bus.cpu_tick) mask[c] = 1'b1;
        end
        check("default_div_mask", mask, 32'h0000_0040);

        // DIV=4: ticks at 4, 8 and 12 cycles after the run edge.
        drive(1, 0, 0, 0, 0, 0, 8'd0); cyc();
        drive(0, 0, 0, 0, 0, 1, 8'd4); cyc();
        drive(0, 1, 0, 0, 0, 0, 8'd0); cyc();
        mask = '0;
        for (int c = 1; c <= 13; c++) begin
            idle(); cyc();
            if (bus.cpu_tick) mask[c] = 1'b1;
        end
        check("div4_tick_mask", mask, 32'h0000_1110);

        // Halt on the terminal-count cycle suppresses the tick; HALTED is terminal.
        drive(1, 0, 0, 0, 0, 0, 8'd0); cyc();
        drive(0, 0, 0, 0, 0, 1, 8'd4); cyc();
        drive(0, 1, 0, 0, 0, 0, 8'd0); cyc();
        for (int c = 1; c <= 3; c++) begin idle(); cyc(); end
        drive(0, 0, 0, 0, 1, 0, 8'd0); cyc();
        check("halt_tc_tick", {31'd0, bus.cpu_tick}, 32'd0);
        check("halt_tc_state", {30'd0, bus.state_o}, {30'd0, ST_HALTED});
        drive(0, 1, 0, 0, 0, 0, 8'd0); cyc();
        drive(0, 0, 1, 0, 0, 0, 8'd0); cyc();
        check("halted_ignore_tick", {31'd0, bus.cpu_tick}, 32'd0);
        check("halted_ignore_state", {30'd0, bus.state_o}, {30'd0, ST_HALTED});

        // Mid-count reload from 8 to 3: next tick exactly 3 cycles after the load.
        drive(1, 0, 0, 0, 0, 0, 8'd0); cyc();
        drive(0, 0, 0, 0, 0, 1, 8'd8); cyc();
        drive(0, 1, 0, 0, 0, 0, 8'd0); cyc();
        for (int c = 1; c <= 3; c++) begin idle(); cyc(); end
        drive(0, 0, 0, 0, 0, 1, 8'd3); cyc();
        check("load_cycle_no_tick", {31'd0, bus.cpu_tick}, 32'd0);
        first = -1;
        k = 0;
        while (first < 0 && k < 20) begin
            k++;
            idle(); cyc();
            if (bus.cpu_tick) first = k;
        end
        check("reload_latency", first, 3);

        // Tick counter: 5 steps plus 3 run ticks.
        drive(1, 0, 0, 0, 0, 0, 8'd0); cyc();
        for (int s = 0; s < 5; s++) begin
            drive(0, 0, 1, 0, 0, 0, 8'd0); cyc();
            idle(); cyc();
        end
        drive(0, 0, 0, 0, 0, 1, 8'd4); cyc();
        drive(0, 1, 0, 0, 0, 0, 8'd0); cyc();
        for (int c = 1; c <= 12; c++) begin idle(); cyc(); end
        drive(0, 0, 0, 1, 0, 0, 8'd0); cyc();
        idle(); cyc();
`ifdef CLOCK_CTRL_CYCLE_COUNT_EN
        exp_cnt = 32'd8;
`else
        exp_cnt = 32'd0;
`endif
        check("tick_count_8", bus.tick_count, exp_cnt);
        drive(1, 0, 0, 0, 0, 0, 8'd0); cyc();
        check("tick_count_reset", bus.tick_count, 32'd0);

        // Randomized traffic against the model.
        for (int n = 0; n < 3000; n++) begin
            drive(($urandom_range(0, 149) == 0),
                  ($urandom_range(0, 19) == 0),
                  ($urandom_range(0, 9) == 0),
                  ($urandom_range(0, 24) == 0),
                  ($urandom_range(0, 299) == 0),
                  ($urandom_range(0, 29) == 0),
                  8'($urandom_range(0, 5)));
            cyc();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
